// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic family (adder now,
// subtractor and multiplier later): state encodings and default width.
package serial_arith_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } serial_state_t;

endpackage

// File: rtl/full_adder_mux2_1.sv
// One-bit full adder built only from 2:1 multiplexer selects.
// This is the single combinational cell that the serial datapath steps through.
module full_adder_mux2_1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);

    logic w_prop;

    // Propagate is a mux that selects between b and its inverse.
    // When propagate is set, the carry passes through; otherwise it is generated from a.
    assign w_prop    = a ? ~b : b;
    assign sum       = w_prop ? ~c_in : c_in;
    assign carry_out = w_prop ? c_in : a;

endmodule

// File: rtl/bit_serial_adder.sv
// Start/busy/done controlled adder that feeds operands LSB first through a
// single full-adder cell. The carry stays in a flop between bit steps.
module bit_serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    serial_state_t    r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_cy;
    logic             r_carry_out;
    logic [CNT_W-1:0] r_cnt;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_accept;
    logic [WIDTH-1:0] w_sum_next;

    full_adder_mux2_1 u_fa (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .c_in      (r_cy),
        .sum       (w_fa_sum),
        .carry_out (w_fa_cout)
    );

    // DONE accepts a new request just like IDLE, which allows back-to-back operations.
    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_sum_next = {w_fa_sum, r_sum_sh[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_sum_sh    <= '0;
            r_sum       <= '0;
            r_cy        <= 1'b0;
            r_carry_out <= 1'b0;
            r_cnt       <= '0;
        end else if (w_accept) begin
            r_a_sh   <= a_in;
            r_b_sh   <= b_in;
            r_cy     <= c_in;
            r_sum_sh <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_sum_sh <= w_sum_next;
                    r_cy     <= w_fa_cout;
                    r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // The visible result changes only here and holds until the next final bit.
                    if (r_cnt == LAST_BIT) begin
                        r_sum       <= w_sum_next;
                        r_carry_out <= w_fa_cout;
                        r_state     <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign sum       = r_sum;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed bench for bit_serial_adder at WIDTH=8: table-driven additions plus
// hand-written reset, ignored-start, back-to-back and abort sequences.
module tb_bit_serial_adder;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] expSum;
        logic       expCout;
    } vector_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a_in = 8'h00;
    logic [7:0] b_in = 8'h00;
    logic       c_in = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       carry_out;

    int checks = 0;
    int errors = 0;

    vector_t vectors [8];

    bit_serial_adder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Presents one request for a single accepting edge, returning at the first RUN negedge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic hold);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        c_in  = cin;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Counts busy negedges until done shows up, with a bounded wait.
    task automatic waitDone(output int busyCycles);
        int guard;
        busyCycles = 0;
        guard = 0;
        while (!done && guard < 40) begin
            if (busy) busyCycles++;
            guard++;
            @(negedge clk);
        end
        checkOutput("doneSeen", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cycles;
        int donePulses;

        vectors[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vectors[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vectors[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vectors[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vectors[4] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
        vectors[5] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vectors[6] = '{8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0};
        vectors[7] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        // Reset held with random inputs toggling
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_in  = 8'($urandom);
            b_in  = 8'($urandom);
            c_in  = 1'($urandom);
            start = 1'($urandom);
        end
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetSum", 32'(sum), 32'h00);
        checkOutput("resetCout", 32'(carry_out), 32'd0);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].a, vectors[i].b, vectors[i].cin, 1'b0);
            waitDone(cycles);
            checkOutput($sformatf("vec%0d.busyCycles", i), 32'(cycles), 32'd8);
            checkOutput($sformatf("vec%0d.sum", i), 32'(sum), 32'(vectors[i].expSum));
            checkOutput($sformatf("vec%0d.cout", i), 32'(carry_out), 32'(vectors[i].expCout));
            @(negedge clk);
            checkOutput($sformatf("vec%0d.donePulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("vec%0d.sumHold", i), 32'(sum), 32'(vectors[i].expSum));
        end

        // Mid-cycle reset clears the held result without any clock edge
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("asyncResetSum", 32'(sum), 32'h00);
        checkOutput("asyncResetBusy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start during RUN is ignored
        applyStimulus(8'h10, 8'h20, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        a_in  = 8'hAA;
        b_in  = 8'h55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(cycles);
        checkOutput("ignored.remainingBusy", 32'(cycles), 32'd5);
        checkOutput("ignored.sum", 32'(sum), 32'h30);
        checkOutput("ignored.cout", 32'(carry_out), 32'd0);
        donePulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) donePulses++;
        end
        checkOutput("ignored.noSecondOp", 32'(donePulses), 32'd0);

        // Back-to-back with start held high
        applyStimulus(8'h01, 8'h02, 1'b0, 1'b1);
        waitDone(cycles);
        checkOutput("b2b.firstBusy", 32'(cycles), 32'd8);
        checkOutput("b2b.firstSum", 32'(sum), 32'h03);
        a_in = 8'h80;
        b_in = 8'h80;
        c_in = 1'b0;
        @(negedge clk);
        checkOutput("b2b.reaccepted", 32'(busy), 32'd1);
        checkOutput("b2b.sumHeld", 32'(sum), 32'h03);
        waitDone(cycles);
        start = 1'b0;
        checkOutput("b2b.secondBusy", 32'(cycles), 32'd8);
        checkOutput("b2b.secondSum", 32'(sum), 32'h00);
        checkOutput("b2b.secondCout", 32'(carry_out), 32'd1);
        @(negedge clk);
        checkOutput("b2b.idleAfter", 32'({busy, done}), 32'd0);

        // Abort in RUN cycle 4, then a clean rerun
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort.busy", 32'(busy), 32'd0);
        checkOutput("abort.sum", 32'(sum), 32'h00);
        donePulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) donePulses++;
        end
        checkOutput("abort.noDone", 32'(donePulses), 32'd0);
        rst_n = 1'b1;
        applyStimulus(8'h0F, 8'h01, 1'b0, 1'b0);
        waitDone(cycles);
        checkOutput("rerun.busyCycles", 32'(cycles), 32'd8);
        checkOutput("rerun.sum", 32'(sum), 32'h10);
        checkOutput("rerun.cout", 32'(carry_out), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Sequential, area-minimal adder that adds two WIDTH-bit operands one bit per clock, LSB first, through a single instance of the team's mux-built full-adder cell, `full_adder_mux2_1`. The carry is held in a flip-flop between bit steps. The block sits directly downstream of that cell and is its first sequential consumer. It gives the design a start/busy/done-controlled adder whose registered result stays stable between operations.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits; legal range WIDTH >= 2.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to begin an addition; sampled only in IDLE or DONE.
- a_in  in  WIDTH  operand A; captured on the accepting edge.
- b_in  in  WIDTH  operand B; captured on the accepting edge.
- c_in  in  1  carry-in; captured on the accepting edge.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; the result is valid from this cycle.
- sum  out  WIDTH  registered result, equal to (a+b+c_in) mod 2^WIDTH.
- carry_out  out  1  registered bit WIDTH of a+b+c_in.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, start=1: load a_sh<=a_in, b_sh<=b_in, cy<=c_in, sum_sh<=0, cnt<=0, then go to RUN. With start=0, stay in IDLE.
- RUN, each cycle:
  - The full adder takes a_sh[0], b_sh[0] and cy.
  - sum_sh<={fa_sum, sum_sh[WIDTH-1:1]} and cy<=fa_cout.
  - a_sh and b_sh shift right by 1, zero-filled.
  - cnt<=cnt+1.
- RUN, final bit (cnt==WIDTH-1): also load sum<={fa_sum, sum_sh[WIDTH-1:1]} and carry_out<=fa_cout, then go to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 is accepted exactly as in IDLE, giving back-to-back operation.
  - Otherwise go to IDLE.
- start is ignored while in RUN, and operand inputs are don't-care there.
- sum and carry_out change only on the final-bit edge. They hold their value through IDLE and through the next operation's RUN.
- cnt width is $clog2(WIDTH) bits. It never wraps, because it is cleared on accept.
- Outputs:
  - busy = (state==RUN).
  - done = (state==DONE).
  - Both decode directly from the state register, so neither passes through combinational logic from any input.

## Timing
- Reset (rst_n=0, effective immediately, with no clock needed):
  - state=IDLE.
  - busy=0, done=0.
  - sum=0, carry_out=0.
  - All shift registers, cy and cnt are 0.
- Reset mid-RUN aborts the operation: no done pulse, and the result is cleared to 0.
- Latency:
  - Accepting edge E0; busy is high from E0 to E0+WIDTH, i.e. exactly WIDTH cycles.
  - Result registers update at edge E0+WIDTH.
  - done is high between E0+WIDTH and E0+WIDTH+1.
- Throughput: one addition per WIDTH+1 cycles when start is held high continuously, because a new operation is accepted in the DONE cycle.
- The full-adder path is purely combinational, one cell deep between flops.

## Structure
- Shared package `serial_arith_pkg`:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - default WIDTH constant.
  - The future serial subtractor and multiplier reuse this package.
- Exactly one sub-module: `full_adder_mux2_1`, instantiated once. Connections:
  - a <- a_sh[0]
  - b <- b_sh[0]
  - c_in <- cy
  - sum -> fa_sum
  - carry_out -> fa_cout
- Everything else (FSM, counter, shift registers, result registers) is in bit_serial_adder.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold rst_n=0 with random inputs -> busy=0, done=0, sum=8'h00, carry_out=0. Assert rst_n mid-cycle -> outputs clear before the next clock edge.
- Basic add: a_in=8'h35, b_in=8'h4A, c_in=0, one start pulse -> busy high exactly 8 cycles, then a single done pulse with sum=8'h7F, carry_out=0. The result holds afterwards.
- Full ripple:
  - 8'hFF + 8'h01, c_in=0 -> sum=8'h00, carry_out=1.
  - 8'hFF + 8'hFF, c_in=1 -> sum=8'hFF, carry_out=1.
- Ignored start: start 8'h10 + 8'h20. At RUN cycle 3, pulse start with 8'hAA + 8'h55 -> result 8'h30, carry 0, and only one done pulse.
- Back-to-back: hold start=1. The first op 8'h01 + 8'h02 gives sum=8'h03. Operands 8'h80 + 8'h80 are presented in the DONE cycle and accepted there -> next done 9 cycles later with sum=8'h00, carry_out=1. sum stays 8'h03 in between.
- Abort: assert rst_n=0 during RUN cycle 4 of 8'h0F + 8'h01 -> no done, sum=0. After release, start 8'h0F + 8'h01 -> sum=8'h10.
